// File: rtl/tetris_vga_render_if.sv
// Video-side bundle for the Tetris VGA renderer.
// Ports: display_array (game->renderer), hsync/vsync/rgb/frame_start (renderer->display).
`timescale 1ns/1ps
interface tetris_vga_render_if;
  logic [21:0][9:0] display_array;
  logic             hsync;
  logic             vsync;
  logic [11:0]      rgb;
  logic             frame_start;

  modport master (
    output display_array,
    input  hsync, vsync, rgb, frame_start
  );

  modport slave (
    input  display_array,
    output hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/tetris_vga_render.sv
// 640x480@60 VGA renderer for a 10x20 Tetris playfield, framed from a per-frame snapshot.
// Ports: clk (25 MHz), reset (async, active-high), vga (slave: display_array in;
//   hsync/vsync active-low, rgb {R4,G4,B4}, frame_start pulse out).
// Optional: define TETRIS_VGA_GRID_LINES_EN to draw LINE_RGB on cell borders.
`timescale 1ns/1ps
module tetris_vga_render #(
  parameter logic [11:0] FILL_RGB  = 12'hF80,
  parameter logic [11:0] EMPTY_RGB = 12'h111,
  parameter logic [11:0] BG_RGB    = 12'h000,
  parameter logic [11:0] LINE_RGB  = 12'h444
) (
  input  logic clk,
  input  logic reset,
  tetris_vga_render_if.slave vga
);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [4:0] cph_q, cph_d;
  logic [3:0] col_q, col_d;
  logic [4:0] rph_q, rph_d;
  logic [4:0] row_q, row_d;
  logic [19:0][9:0] snap_q;

  logic snap_tick;
  logic hs_raw, vs_raw;
  logic pf_d, act_d, cell_d;

  logic pf1_q, act1_q, cell1_q, hs1_q, vs1_q;
  logic [11:0] rgb_d, rgb_q;
  logic hs2_q, vs2_q;

  always_comb begin
    hcnt_d = (hcnt_q == 10'd799) ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == 10'd799)
      vcnt_d = (vcnt_q == 10'd524) ? 10'd0 : vcnt_q + 10'd1;
  end

  // Phase/index counters track the pixel the counters point at;
  // they are re-armed one pixel/line before the playfield edge.
  always_comb begin
    cph_d = cph_q;
    col_d = col_q;
    if (hcnt_q == 10'd219) begin
      cph_d = 5'd0;
      col_d = 4'd0;
    end else if (cph_q == 5'd19) begin
      cph_d = 5'd0;
      if (col_q != 4'd9)
        col_d = col_q + 4'd1;
    end else begin
      cph_d = cph_q + 5'd1;
    end
  end

  always_comb begin
    rph_d = rph_q;
    row_d = row_q;
    if (hcnt_q == 10'd799) begin
      if (vcnt_q == 10'd39) begin
        rph_d = 5'd0;
        row_d = 5'd0;
      end else if (rph_q == 5'd19) begin
        rph_d = 5'd0;
        if (row_q != 5'd19)
          row_d = row_q + 5'd1;
      end else begin
        rph_d = rph_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      cph_q  <= '0;
      col_q  <= '0;
      rph_q  <= '0;
      row_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      cph_q  <= cph_d;
      col_q  <= col_d;
      rph_q  <= rph_d;
      row_q  <= row_d;
    end
  end

  assign snap_tick = (hcnt_q == 10'd0) && (vcnt_q == 10'd480);

  // Snapshot is taken in vertical blanking, so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      snap_q <= '0;
    else if (snap_tick)
      snap_q <= vga.display_array[19:0];
  end

  always_comb begin
    hs_raw = !((hcnt_q >= 10'd656) && (hcnt_q <= 10'd751));
    vs_raw = !((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491));
    act_d  = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
    pf_d   = (hcnt_q >= 10'd220) && (hcnt_q <= 10'd419) &&
             (vcnt_q >= 10'd40)  && (vcnt_q <= 10'd439);
    cell_d = snap_q[row_q][col_q];
  end

`ifdef TETRIS_VGA_GRID_LINES_EN
  logic line_d, line1_q;
  assign line_d = (cph_q == 5'd0) || (rph_q == 5'd0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      line1_q <= 1'b0;
    else
      line1_q <= line_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf1_q   <= 1'b0;
      act1_q  <= 1'b0;
      cell1_q <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
    end else begin
      pf1_q   <= pf_d;
      act1_q  <= act_d;
      cell1_q <= cell_d;
      hs1_q   <= hs_raw;
      vs1_q   <= vs_raw;
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (act1_q) begin
      if (!pf1_q)
        rgb_d = BG_RGB;
`ifdef TETRIS_VGA_GRID_LINES_EN
      else if (line1_q)
        rgb_d = LINE_RGB;
`endif
      else if (cell1_q)
        rgb_d = FILL_RGB;
      else
        rgb_d = EMPTY_RGB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign vga.rgb         = rgb_q;
  assign vga.hsync       = hs2_q;
  assign vga.vsync       = vs2_q;
  assign vga.frame_start = snap_tick;

  // Rows 20-21 are hidden spawn rows and never rendered.
  logic unused_ok;
`ifdef TETRIS_VGA_GRID_LINES_EN
  assign unused_ok = ^vga.display_array[21:20];
`else
  assign unused_ok = ^{vga.display_array[21:20], LINE_RGB};
`endif

endmodule

// File: doc/tetris_vga_render.md
TETRIS_VGA_RENDER -- requirements
Module: tetris_vga_render

Interface
REQ-001 Parameter FILL_RGB, default 12'hF80: colour of an occupied cell.
REQ-002 Parameter EMPTY_RGB, default 12'h111: colour of an empty cell inside the playfield.
REQ-003 Parameter BG_RGB, default 12'h000: colour of an active pixel outside the playfield.
REQ-004 Parameter LINE_RGB, default 12'h444: colour of a grid line (only with GRID_LINES_EN).
REQ-005 clk  input  1  25 MHz pixel clock; reset  input  1  asynchronous, active-high.
REQ-006 display_array  input  22x10  playfield from the game FSM; bit [r][c] = row r (0 = top), column c (0 = left); rows 20-21 are ignored.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 rgb  output  12  pixel colour {R4,G4,B4}.
REQ-010 frame_start  output  1  one-cycle pulse when the snapshot is taken.

Function
REQ-011 hcnt SHALL count 0..799 and wrap to 0; vcnt SHALL increment when hcnt wraps, count 0..524, and wrap to 0.
REQ-012 Raw sync timing SHALL be as follows: hsync low for hcnt 656..751; vsync low for vcnt 490..491; active video is hcnt<640 and vcnt<480.
REQ-013 At hcnt==0 and vcnt==480, rows 0..19 of display_array SHALL be copied into an internal snapshot, and frame_start SHALL pulse in that same cycle.
REQ-014 Rendering SHALL use only the snapshot, so the displayed grid stays unchanged for an entire frame.
REQ-015 The playfield SHALL span hcnt 220..419 and vcnt 40..439, with 20x20-pixel cells.
REQ-016 Cell column and row indices SHALL be produced by phase counters (0..19) and index counters; no divider or multiplier SHALL be used.
REQ-017 The column index SHALL reset at hcnt==220 and advance when its phase counter wraps from 19 to 0; the row index SHALL reset at vcnt==40 and advance on the same rule, updated only at hcnt==799.
REQ-018 Pixel pipeline stage 1 SHALL register the inside-playfield flag, the active flag and the cell bit; stage 2 SHALL register the colour select.
REQ-019 rgb SHALL lag the counters by exactly 2 clocks.
REQ-020 hsync and vsync SHALL be delayed by 2 clocks so they stay aligned with rgb.
REQ-021 rgb SHALL be 0 whenever the pixel is outside active video.
REQ-022 Inside the playfield, rgb SHALL be FILL_RGB for snapshot bit 1 and EMPTY_RGB for bit 0; elsewhere in active video it SHALL be BG_RGB.
REQ-023 Changes on display_array between snapshots SHALL have no visible effect.

Reset
REQ-024 reset SHALL asynchronously clear the following: hcnt, vcnt, phase counters, index counters, the snapshot and all pipeline registers.
REQ-025 While reset is asserted, the outputs SHALL be rgb=0, hsync=1, vsync=1 and frame_start=0.
REQ-026 After reset is released, the first output frame SHALL render an all-empty grid until the first snapshot at vcnt==480.

Configuration
REQ-027 With macro TETRIS_VGA_GRID_LINES_EN defined, playfield pixels whose column phase is 0 or whose row phase is 0 SHALL output LINE_RGB regardless of the cell bit.
REQ-028 Without TETRIS_VGA_GRID_LINES_EN, no grid-line logic SHALL be present and every playfield pixel SHALL follow REQ-022.

Verification
REQ-029 Reset, release, then run 420000 clocks -> hsync period is 800 clocks with a 96-clock low pulse; vsync period is 420000 clocks with a low pulse of 2 lines (1600 clocks); frame_start fires once per frame.
REQ-030 display_array[0][0]=1 only, snapshot taken -> rgb=FILL_RGB for counter h 220..239 and v 40..59, observed 2 clocks later; other playfield pixels are EMPTY_RGB.
REQ-031 display_array[19][9]=1 plus [20][0]=1 and [21][5]=1 -> only the h 400..419, v 420..439 cell is FILL_RGB; rows 20 and 21 are never displayed.
REQ-032 display_array toggled at vcnt==200 mid-frame -> the current frame is unchanged; the change appears after the next frame_start.
REQ-033 reset asserted at hcnt=300, vcnt=100 -> outputs go immediately to rgb=0, hsync=1, vsync=1; after release the counters restart from 0 and the grid is empty.
REQ-034 With TETRIS_VGA_GRID_LINES_EN and an all-ones grid -> h=220 and h=240 show LINE_RGB, h=221 shows FILL_RGB, and v=40 across the whole playfield shows LINE_RGB.
